// File: rtl/multicycle_alu_if.sv
// Start/Busy/Done handshake bundle between the control unit (master)
// and the multicycle ALU (slave).
interface multicycle_alu_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [4:0]       FunSel;
    logic             MulDiv;
    logic             WF;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] ResultHi;
    logic             Busy;
    logic             Done;
    logic [3:0]       FlagsOut;
    logic             DivByZero;

    modport master (
        output Start, FunSel, MulDiv, WF, A, B,
        input  Result, ResultHi, Busy, Done, FlagsOut, DivByZero
    );

    modport slave (
        input  Start, FunSel, MulDiv, WF, A, B,
        output Result, ResultHi, Busy, Done, FlagsOut, DivByZero
    );
endinterface

// File: rtl/multicycle_alu.sv
// WIDTH-bit ALU with half-width mode: single-edge base ops plus iterative
// shift-add multiply and restoring divide, all behind a Start/Done handshake.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input logic            Clock,
    input logic            Reset,
    multicycle_alu_if.slave bus
);
    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             op_full, op_div, op_wf;
    logic [WIDTH-1:0] hi, lo, opnd;
    logic [WIDTH-1:0] result, result_hi;
    logic [3:0]       flags;
    logic             done, dbz;
    logic             accept;

    assign accept        = bus.Start && (state != ITER);
    assign bus.Busy      = (state == ITER);
    assign bus.Result    = result;
    assign bus.ResultHi  = result_hi;
    assign bus.Done      = done;
    assign bus.FlagsOut  = flags;
    assign bus.DivByZero = dbz;

    logic [WIDTH-1:0] msk, top, am, bm, bop, base_res;
    logic [WIDTH:0]   sum;
    logic [3:0]       base_flags;
    logic             cin, cout, a_top, b_top, r_top, shc, zero;

    // Base operations on the live operands, masked to the selected width.
    always_comb begin
        msk      = bus.FunSel[4] ? '1 : {{HALF{1'b0}}, {HALF{1'b1}}};
        top      = bus.FunSel[4] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {{HALF{1'b0}}, 1'b1, {(HALF-1){1'b0}}};
        am       = bus.A & msk;
        bm       = bus.B & msk;
        bop      = (bus.FunSel[3:0] == 4'h6) ? (~bus.B & msk) : bm;
        cin      = (bus.FunSel[3:0] == 4'h6) ? 1'b1 :
                   (bus.FunSel[3:0] == 4'h5) ? flags[2] : 1'b0;
        sum      = {1'b0, am} + {1'b0, bop} + {{WIDTH{1'b0}}, cin};
        cout     = bus.FunSel[4] ? sum[WIDTH] : sum[HALF];
        a_top    = |(am & top);
        b_top    = |(bop & top);
        base_res = '0;
        shc      = 1'b0;
        case (bus.FunSel[3:0])
            4'h0: base_res = am;
            4'h1: base_res = bm;
            4'h2: base_res = ~bus.A & msk;
            4'h3: base_res = ~bus.B & msk;
            4'h4, 4'h5, 4'h6: base_res = sum[WIDTH-1:0] & msk;
            4'h7: base_res = am & bm;
            4'h8: base_res = am | bm;
            4'h9: base_res = am ^ bm;
            4'hA: base_res = ~(am & bm) & msk;
            4'hB: begin base_res = (am << 1) & msk; shc = a_top; end
            4'hC: begin base_res = am >> 1; shc = am[0]; end
            4'hD: begin base_res = (am >> 1) | (a_top ? top : '0); shc = am[0]; end
            4'hE: begin base_res = ((am << 1) & msk) | {{(WIDTH-1){1'b0}}, a_top}; shc = a_top; end
            default: begin base_res = (am >> 1) | (am[0] ? top : '0); shc = am[0]; end
        endcase
        r_top = |(base_res & top);
        zero  = (base_res == '0);
        case (bus.FunSel[3:0])
            4'h4, 4'h5, 4'h6: base_flags = {zero, cout, r_top, (a_top == b_top) && (r_top != a_top)};
            4'h7, 4'h8, 4'h9, 4'hA: base_flags = 4'b0000;
            4'hB, 4'hC, 4'hD, 4'hE, 4'hF: base_flags = {zero, shc, r_top, 1'b0};
            default: base_flags = {zero, 1'b0, r_top, 1'b0};
        endcase
    end

    logic [WIDTH-1:0] op_msk, op_top, hi_nx, lo_nx, quot;
    logic [WIDTH:0]   madd, rsh, rdiff;

    // One iteration step; the divide dividend is pre-aligned to the MSB so
    // both widths shift out of lo[WIDTH-1].
    always_comb begin
        op_msk = op_full ? '1 : {{HALF{1'b0}}, {HALF{1'b1}}};
        op_top = op_full ? {1'b1, {(WIDTH-1){1'b0}}}
                         : {{HALF{1'b0}}, 1'b1, {(HALF-1){1'b0}}};
        madd   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        rsh    = {hi, lo[WIDTH-1]};
        rdiff  = rsh - {1'b0, opnd};
        if (op_div) begin
            if (!rdiff[WIDTH]) begin
                hi_nx = rdiff[WIDTH-1:0];
                lo_nx = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nx = rsh[WIDTH-1:0];
                lo_nx = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nx = madd[WIDTH:1];
            lo_nx = (lo >> 1) | (madd[0] ? op_top : '0);
        end
        quot = lo_nx & op_msk;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op_full   <= 1'b0;
            op_div    <= 1'b0;
            op_wf     <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            opnd      <= '0;
            result    <= '0;
            result_hi <= '0;
            flags     <= 4'b0000;
            done      <= 1'b0;
            dbz       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                dbz <= 1'b0;
                if (!bus.MulDiv) begin
                    state     <= IDLE;
                    result    <= base_res;
                    result_hi <= '0;
                    done      <= 1'b1;
                    if (bus.WF) flags <= base_flags;
                end else if (bus.FunSel[0] && (bm == '0)) begin
                    state     <= IDLE;
                    result    <= msk;
                    result_hi <= am;
                    done      <= 1'b1;
                    dbz       <= 1'b1;
                    if (bus.WF) flags <= 4'b0000;
                end else begin
                    state   <= ITER;
                    cnt     <= bus.FunSel[4] ? CW'(WIDTH) : CW'(HALF);
                    op_full <= bus.FunSel[4];
                    op_div  <= bus.FunSel[0];
                    op_wf   <= bus.WF;
                    hi      <= '0;
                    opnd    <= bus.FunSel[0] ? bm : am;
                    if (bus.FunSel[0])
                        lo <= bus.FunSel[4] ? bus.A : {bus.A[HALF-1:0], {HALF{1'b0}}};
                    else
                        lo <= bm;
                end
            end else if (state == ITER) begin
                hi  <= hi_nx;
                lo  <= lo_nx;
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    state     <= FIN;
                    done      <= 1'b1;
                    result    <= quot;
                    result_hi <= hi_nx;
                    if (op_wf)
                        flags <= op_div ? {quot == '0, 3'b000}
                                        : {{hi_nx, quot} == '0, hi_nx != '0, |(quot & op_top), 1'b0};
                end
            end else if (state == FIN) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: base ops, iterative multiply/divide,
// handshake timing, back-to-back issue and reset abort.
module tb_multicycle_alu;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   failed = 0;
    int   edges;
    int   busyCycles;

    always #5 clk = ~clk;

    multicycle_alu_if #(.WIDTH(32)) bus ();

    multicycle_alu #(.WIDTH(32)) dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one op from the current time and returns just after the edge
    // that raised Done, with the edge count (bounded) in edges.
    task automatic applyStimulus(input logic [4:0] fs, input logic md, input logic wf,
                                 input logic [31:0] a, input logic [31:0] b);
        bus.FunSel = fs;
        bus.MulDiv = md;
        bus.WF     = wf;
        bus.A      = a;
        bus.B      = b;
        bus.Start  = 1'b1;
        edges      = 0;
        busyCycles = 0;
        @(posedge clk);
        #1;
        edges     = 1;
        bus.Start = 1'b0;
        while (bus.Done !== 1'b1 && edges < 100) begin
            if (bus.Busy === 1'b1) busyCycles++;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic checkOp(input string tag, input int expEdges, input logic [31:0] expRes,
                           input logic [31:0] expHi, input logic [3:0] expFlags);
        checkOutput({tag, ".latency"}, 32'(edges), 32'(expEdges));
        checkOutput({tag, ".result"}, bus.Result, expRes);
        checkOutput({tag, ".resultHi"}, bus.ResultHi, expHi);
        checkOutput({tag, ".flags"}, {28'd0, bus.FlagsOut}, {28'd0, expFlags});
    endtask

    initial begin
        bus.Start  = 1'b0;
        bus.FunSel = 5'h00;
        bus.MulDiv = 1'b0;
        bus.WF     = 1'b0;
        bus.A      = '0;
        bus.B      = '0;

        #3;
        checkOutput("reset.result", bus.Result, 32'h0);
        checkOutput("reset.resultHi", bus.ResultHi, 32'h0);
        checkOutput("reset.ctrl", {27'd0, bus.Busy, bus.Done, bus.DivByZero, 2'd0}, 32'h0);
        checkOutput("reset.flags", {28'd0, bus.FlagsOut}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        applyStimulus(5'h14, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1);
        checkOp("addFull", 1, 32'h0, 32'h0, 4'b1100);
        checkOutput("addFull.busy", 32'(busyCycles), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("addFull.donePulse", {31'd0, bus.Done}, 32'd0);

        @(negedge clk);
        applyStimulus(5'h04, 1'b0, 1'b1, 32'h1234_7FFF, 32'h1);
        checkOp("addHalf", 1, 32'h0000_8000, 32'h0, 4'b0011);

        @(negedge clk);
        applyStimulus(5'h16, 1'b0, 1'b1, 32'd5, 32'd5);
        checkOp("sub", 1, 32'h0, 32'h0, 4'b1100);

        @(negedge clk);
        applyStimulus(5'h0D, 1'b0, 1'b1, 32'hFFFF_8001, 32'h0);
        checkOp("asrHalf", 1, 32'h0000_C000, 32'h0, 4'b0110);

        @(negedge clk);
        applyStimulus(5'h17, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        checkOp("and", 1, 32'h0, 32'h0, 4'b0000);

        @(negedge clk);
        applyStimulus(5'h1F, 1'b0, 1'b1, 32'h1, 32'h0);
        checkOp("ror", 1, 32'h8000_0000, 32'h0, 4'b0110);

        @(negedge clk);
        applyStimulus(5'h10, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h2);
        checkOp("mulFull", 33, 32'hFFFF_FFFE, 32'h1, 4'b0110);
        checkOutput("mulFull.busy", 32'(busyCycles), 32'd32);

        @(negedge clk);
        applyStimulus(5'h00, 1'b1, 1'b1, 32'hABCD_1234, 32'h0000_0010);
        checkOp("mulHalf", 17, 32'h0000_2340, 32'h1, 4'b0100);

        @(negedge clk);
        applyStimulus(5'h11, 1'b1, 1'b1, 32'd100, 32'd7);
        checkOp("divFull", 33, 32'd14, 32'd2, 4'b0000);
        applyStimulus(5'h11, 1'b1, 1'b1, 32'd100, 32'd0);
        checkOp("divZero", 1, 32'hFFFF_FFFF, 32'd100, 4'b0000);
        checkOutput("divZero.flag", {31'd0, bus.DivByZero}, 32'd1);

        @(negedge clk);
        applyStimulus(5'h01, 1'b1, 1'b1, 32'hFFFF_03E8, 32'h0001_0003);
        checkOp("divHalf", 17, 32'd333, 32'd1, 4'b0000);
        checkOutput("divHalf.dbzClear", {31'd0, bus.DivByZero}, 32'd0);

        @(negedge clk);
        applyStimulus(5'h14, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1);
        @(negedge clk);
        applyStimulus(5'h15, 1'b0, 1'b0, 32'h1, 32'h1);
        checkOp("adc", 1, 32'd3, 32'h0, 4'b1100);
        applyStimulus(5'h04, 1'b0, 1'b1, 32'h2, 32'h3);
        checkOp("backToBack", 1, 32'd5, 32'h0, 4'b0000);

        @(negedge clk);
        bus.FunSel = 5'h10;
        bus.MulDiv = 1'b1;
        bus.WF     = 1'b1;
        bus.A      = 32'd3;
        bus.B      = 32'd5;
        bus.Start  = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.FunSel = 5'h14;
        bus.MulDiv = 1'b0;
        bus.Start  = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        checkOutput("ignored.busy", {31'd0, bus.Busy}, 32'd1);
        checkOutput("ignored.done", {31'd0, bus.Done}, 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort.result", bus.Result, 32'h0);
        checkOutput("abort.resultHi", bus.ResultHi, 32'h0);
        checkOutput("abort.ctrl", {29'd0, bus.Busy, bus.Done, bus.DivByZero}, 32'h0);
        checkOutput("abort.flags", {28'd0, bus.FlagsOut}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("abort.noDone", {31'd0, bus.Done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        applyStimulus(5'h10, 1'b1, 1'b1, 32'h8000_0000, 32'd3);
        checkOp("recover", 33, 32'h8000_0000, 32'h1, 4'b0110);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
